// File: rtl/ioctl_stream_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : ioctl_stream_buffer_if
// Function : HPS ioctl download stream and paced loader byte stream
// Revision : 1.0 - initial release
// ============================================================================
interface ioctl_stream_buffer_if;
  logic       ioctl_download;
  logic       ioctl_wr;
  logic [7:0] ioctl_dout;
  logic [7:0] ioctl_index;
  logic       ioctl_wait;
  logic       out_ready;
  logic       out_strobe;
  logic [7:0] out_data;
  logic [7:0] out_index;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_dout, ioctl_index, out_ready,
    input  ioctl_wait, out_strobe, out_data, out_index
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_dout, ioctl_index, out_ready,
    output ioctl_wait, out_strobe, out_data, out_index
  );
endinterface
`default_nettype wire

// File: rtl/ioctl_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ioctl_stream_buffer
// Function : FIFO between HPS ioctl stream and loader with paced strobes,
//            post-download reset stretch; IOCTL_STREAM_CHECKSUM_EN adds checksum
// Revision : 1.0 - initial release
// ============================================================================
module ioctl_stream_buffer #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int PACE     = 4,
  parameter int RST_HOLD = 255
) (
  input  wire logic             CLK_50M,
  input  wire logic             reset,
  ioctl_stream_buffer_if.slave  bus,
  output logic                  download_reset,
  output logic [21:0]           byte_count,
  output logic                  overflow
`ifdef IOCTL_STREAM_CHECKSUM_EN
  ,
  output logic [15:0]           checksum,
  output logic                  checksum_valid
`endif
);

  localparam int c_PACE_W = (PACE > 1) ? $clog2(PACE) : 1;
  localparam int c_HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [c_PACE_W-1:0] c_PACE_RELOAD = c_PACE_W'(PACE - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD   = c_HOLD_W'(RST_HOLD);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST   = c_HOLD_W'(1);
  localparam logic [AW:0]         c_DEPTH       = (AW + 1)'(DEPTH);
  localparam logic [AW:0]         c_WAIT_LVL    = (AW + 1)'(DEPTH - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                r_state;
  logic [7:0]            r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic [c_PACE_W-1:0]   r_pace;
  logic [c_HOLD_W-1:0]   r_hold;
  logic                  r_download_d;
  logic                  r_wait;
  logic                  r_out_strobe;
  logic [7:0]            r_out_data;
  logic [7:0]            r_out_index;
  logic [21:0]           r_byte_count;
  logic                  r_overflow;
`ifdef IOCTL_STREAM_CHECKSUM_EN
  logic [15:0]           r_checksum;
  logic                  r_checksum_valid;
`endif

  logic                  w_active;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_fall;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic [AW:0]           w_count_next;

  // Full/empty come from the pre-cycle occupancy, so a push into a full
  // FIFO is dropped even when a pop happens in the same cycle.
  always_comb begin
    w_active     = (r_state == S_LOAD) || (r_state == S_DRAIN);
    w_full       = (r_count == c_DEPTH);
    w_empty      = (r_count == '0);
    w_fall       = r_download_d && !bus.ioctl_download;
    w_push       = (r_state == S_LOAD) && bus.ioctl_wr && !w_full;
    w_drop       = (r_state == S_LOAD) && bus.ioctl_wr && w_full;
    w_pop        = w_active && !w_empty && bus.out_ready && (r_pace == '0);
    w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
  end

  always_ff @(posedge CLK_50M) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.ioctl_dout;
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_pace           <= '0;
      r_hold           <= '0;
      r_download_d     <= 1'b0;
      r_wait           <= 1'b0;
      r_out_strobe     <= 1'b0;
      r_out_data       <= '0;
      r_out_index      <= '0;
      r_byte_count     <= '0;
      r_overflow       <= 1'b0;
`ifdef IOCTL_STREAM_CHECKSUM_EN
      r_checksum       <= '0;
      r_checksum_valid <= 1'b0;
`endif
    end else begin
      r_download_d <= bus.ioctl_download;
      r_out_strobe <= w_pop;
      r_count      <= w_count_next;
      // IDLE and HOLD always have an empty FIFO, so only the active states can raise wait.
      r_wait       <= w_active && (w_count_next >= c_WAIT_LVL);

      if (w_pop) begin
        r_out_data <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_pace     <= c_PACE_RELOAD;
      end else if (r_pace != '0) begin
        r_pace <= r_pace - 1'b1;
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_byte_count != '1) begin
          r_byte_count <= r_byte_count + 1'b1;
        end
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end

`ifdef IOCTL_STREAM_CHECKSUM_EN
      if (r_out_strobe) begin
        r_checksum <= r_checksum + {8'h00, r_out_data};
      end
`endif

      case (r_state)
        S_LOAD: begin
          if (w_fall) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_empty && !r_out_strobe) begin
            r_hold  <= c_HOLD_LOAD;
            r_state <= S_HOLD;
`ifdef IOCTL_STREAM_CHECKSUM_EN
            r_checksum_valid <= 1'b1;
`endif
          end
        end
        default: begin
          // IDLE and HOLD share the download-start restart.
          if (bus.ioctl_download) begin
            r_state      <= S_LOAD;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_byte_count <= '0;
            r_overflow   <= 1'b0;
            r_out_index  <= bus.ioctl_index;
`ifdef IOCTL_STREAM_CHECKSUM_EN
            r_checksum       <= '0;
            r_checksum_valid <= 1'b0;
`endif
          end else if (r_state == S_HOLD) begin
            if (r_hold <= c_HOLD_LAST) begin
              r_state <= S_IDLE;
            end else begin
              r_hold <= r_hold - 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.ioctl_wait = r_wait;
  assign bus.out_strobe = r_out_strobe;
  assign bus.out_data   = r_out_data;
  assign bus.out_index  = r_out_index;
  assign download_reset = (r_state != S_IDLE);
  assign byte_count     = r_byte_count;
  assign overflow       = r_overflow;
`ifdef IOCTL_STREAM_CHECKSUM_EN
  assign checksum       = r_checksum;
  assign checksum_valid = r_checksum_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ioctl_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ioctl_stream_buffer
// Function : directed self-checking bench for ioctl_stream_buffer
// Revision : 1.0 - initial release
// ============================================================================
module tb_ioctl_stream_buffer;

  logic        CLK_50M = 1'b0;
  logic        reset   = 1'b1;
  logic        download_reset;
  logic [21:0] byte_count;
  logic        overflow;
`ifdef IOCTL_STREAM_CHECKSUM_EN
  logic [15:0] checksum;
  logic        checksum_valid;
`endif

  ioctl_stream_buffer_if bus ();

  ioctl_stream_buffer #(
    .DEPTH    (16),
    .AW       (4),
    .PACE     (4),
    .RST_HOLD (255)
  ) dut (
    .CLK_50M        (CLK_50M),
    .reset          (reset),
    .bus            (bus.slave),
    .download_reset (download_reset),
    .byte_count     (byte_count),
    .overflow       (overflow)
`ifdef IOCTL_STREAM_CHECKSUM_EN
    ,
    .checksum       (checksum),
    .checksum_valid (checksum_valid)
`endif
  );

  always #10 CLK_50M = ~CLK_50M;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  int         strobe_cnt = 0;
  int         strobe_cyc_q[$];
  logic [7:0] exp_q[$];
  bit         watch_wait = 0;
  bit         wait_seen = 0;
  bit         dr_watch = 0;
  bit         dr_drop = 0;
  int         push0;
  int         s_last;

  always @(posedge CLK_50M) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest expected byte.
  always @(negedge CLK_50M) begin
    if (bus.out_strobe === 1'b1) begin
      strobe_cnt++;
      strobe_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("strobe_unexpected", 32'(exp_q.size()), 32'd1);
      else chk("strobe_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
    end
    if (watch_wait && bus.ioctl_wait === 1'b1) wait_seen = 1;
    if (dr_watch && download_reset !== 1'b1) dr_drop = 1;
  end

  task automatic tick;
    @(posedge CLK_50M);
    #1;
  endtask

  task automatic start(input logic [7:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [7:0] b, input bit last, input bit accept);
    bus.ioctl_wr       = 1'b1;
    bus.ioctl_dout     = b;
    bus.ioctl_download = !last;
    if (accept) exp_q.push_back(b);
    tick();
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic wait_strobes(input string tag, input int target, input int budget);
    int n = 0;
    while (strobe_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(strobe_cnt), 32'(target));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (download_reset !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(download_reset), 32'd0);
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_dout     = 8'h00;
    bus.ioctl_index    = 8'h00;
    bus.out_ready      = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_wait",    32'(bus.ioctl_wait), 32'd0);
    chk("rst_strobe",  32'(bus.out_strobe), 32'd0);
    chk("rst_index",   32'(bus.out_index), 32'd0);
    chk("rst_dlreset", 32'(download_reset), 32'd0);
    chk("rst_count",   32'(byte_count), 32'd0);
    reset = 1'b0;
    tick();

    // Basic flow: four spaced writes, the last one coincides with the fall
    strobe_cnt = 0;
    strobe_cyc_q.delete();
    start(8'h01);
    chk("basic_index",   32'(bus.out_index), 32'h01);
    chk("basic_dlreset", 32'(download_reset), 32'd1);
    push0 = cyc;
    wr(8'h4E, 0, 1); repeat (9) tick();
    wr(8'h45, 0, 1); repeat (9) tick();
    wr(8'h53, 0, 1); repeat (9) tick();
    wr(8'h1A, 1, 1);
    wait_strobes("basic_strobes", 4, 50);
    chk("basic_latency", 32'(strobe_cyc_q[0] - push0), 32'd2);
    chk("basic_count", 32'(byte_count), 32'd4);
    s_last = strobe_cyc_q[$];
    while (cyc < s_last + 256) tick();
    chk("basic_hold_high", 32'(download_reset), 32'd1);
`ifdef IOCTL_STREAM_CHECKSUM_EN
    chk("basic_checksum", 32'(checksum), 32'h0100);
    chk("basic_ck_valid", 32'(checksum_valid), 32'd1);
`endif
    tick();
    chk("basic_hold_low", 32'(download_reset), 32'd0);

    // Pacing: eight back-to-back writes
    strobe_cnt = 0;
    strobe_cyc_q.delete();
    wait_seen  = 0;
    watch_wait = 1;
    start(8'h02);
    push0 = cyc;
    for (int i = 0; i < 8; i++) wr(8'(8'h10 + i), i == 7, 1);
    wait_strobes("pace_strobes", 8, 80);
    chk("pace_latency", 32'(strobe_cyc_q[0] - push0), 32'd2);
    if (strobe_cyc_q.size() >= 8)
      for (int i = 1; i < 8; i++) chk("pace_gap", 32'(strobe_cyc_q[i] - strobe_cyc_q[i-1]), 32'd4);
    watch_wait = 0;
    chk("pace_no_wait", 32'(wait_seen), 32'd0);
    wait_idle("pace_idle", 400);

    // Back-pressure: loader stalled, 14 writes
    strobe_cnt = 0;
    bus.out_ready = 1'b0;
    start(8'h03);
    for (int i = 0; i < 14; i++) begin
      wr(8'(8'hC0 + i), 0, 1);
      if (i == 12) chk("bp_wait_13", 32'(bus.ioctl_wait), 32'd0);
      if (i == 13) chk("bp_wait_14", 32'(bus.ioctl_wait), 32'd1);
    end
    bus.ioctl_download = 1'b0;
    bus.out_ready      = 1'b1;
    tick();
    chk("bp_wait_fall", 32'(bus.ioctl_wait), 32'd0);
    chk("bp_first_strobe", 32'(bus.out_strobe), 32'd1);
    wait_strobes("bp_strobes", 14, 120);
    wait_idle("bp_idle", 400);

    // Overflow: 17 writes into a stalled FIFO, the last one dropped
    strobe_cnt = 0;
    bus.out_ready = 1'b0;
    start(8'h04);
    for (int i = 0; i < 17; i++) begin
      wr(8'(8'h80 + i), 0, i < 16);
      if (i == 15) chk("ovf_before", 32'(overflow), 32'd0);
    end
    chk("ovf_flag",  32'(overflow), 32'd1);
    chk("ovf_count", 32'(byte_count), 32'd16);
    bus.ioctl_download = 1'b0;
    bus.out_ready      = 1'b1;
    tick();
    wait_strobes("ovf_strobes", 16, 120);
    wait_idle("ovf_idle", 400);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Re-download during HOLD
    strobe_cnt = 0;
    strobe_cyc_q.delete();
    start(8'h01);
    chk("redl_ovf_clear", 32'(overflow), 32'd0);
    dr_drop  = 0;
    dr_watch = 1;
    wr(8'hA5, 0, 1);
    wr(8'h5A, 1, 1);
    wait_strobes("redl_strobes", 2, 50);
    s_last = strobe_cyc_q[$];
    while (cyc < s_last + 102) tick();
    chk("redl_in_hold", 32'(download_reset), 32'd1);
`ifdef IOCTL_STREAM_CHECKSUM_EN
    chk("redl_checksum", 32'(checksum), 32'h00FF);
`endif
    bus.out_ready = 1'b0;
    start(8'h00);
    chk("redl_index",   32'(bus.out_index), 32'h00);
    chk("redl_count",   32'(byte_count), 32'd0);
    chk("redl_dlreset", 32'(download_reset), 32'd1);
`ifdef IOCTL_STREAM_CHECKSUM_EN
    chk("redl_ck_clear", 32'(checksum_valid), 32'd0);
`endif

    // Reset with five bytes buffered
    for (int i = 0; i < 5; i++) wr(8'(8'h30 + i), 0, 0);
    chk("mid_count", 32'(byte_count), 32'd5);
    dr_watch = 0;
    chk("redl_no_drop", 32'(dr_drop), 32'd0);
    reset              = 1'b1;
    bus.ioctl_download = 1'b0;
    tick();
    chk("mrst_wait",    32'(bus.ioctl_wait), 32'd0);
    chk("mrst_strobe",  32'(bus.out_strobe), 32'd0);
    chk("mrst_data",    32'(bus.out_data), 32'd0);
    chk("mrst_dlreset", 32'(download_reset), 32'd0);
    chk("mrst_count",   32'(byte_count), 32'd0);
    chk("mrst_ovf",     32'(overflow), 32'd0);
`ifdef IOCTL_STREAM_CHECKSUM_EN
    chk("mrst_checksum", 32'(checksum), 32'd0);
`endif
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    strobe_cnt    = 0;
    repeat (20) tick();
    chk("mrst_no_strobe", 32'(strobe_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ioctl_stream_buffer.md
Name: ioctl_stream_buffer

Overview:
- Upstream stage of the cartridge/save loader: takes the HPS ioctl byte stream, buffers it in a small FIFO and re-issues bytes to the loader as paced single-cycle strobes.
- Generates the post-download reset stretch that holds the NES core in reset until the last byte has been delivered.
- Throttles the HPS through ioctl_wait when the FIFO nears full.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- AW, 4, FIFO address width; must equal log2(DEPTH).
- PACE, 4, minimum CLK_50M cycles between consecutive out_strobe pulses; minimum 1.
- RST_HOLD, 255, cycles download_reset stays high after the FIFO drains; minimum 1.

Ports:
- CLK_50M  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ioctl_download  in  1  HPS download in progress
- ioctl_wr  in  1  one-cycle byte-valid strobe from the HPS
- ioctl_dout  in  8  download byte
- ioctl_index  in  8  file index (bit0 = 1: NES ROM, 0: SAV)
- ioctl_wait  out  1  back-pressure to the HPS
- out_ready  in  1  loader can accept a byte this cycle
- out_strobe  out  1  one-cycle byte-valid pulse to the loader
- out_data  out  8  byte; valid only while out_strobe = 1
- out_index  out  8  ioctl_index latched at download start
- download_reset  out  1  NES reset request
- byte_count  out  22  bytes accepted in the current/last download
- overflow  out  1  sticky: a byte was dropped

Behaviour:
- Interface: reset reset, synchronous, active-high; clock CLK_50M.
- Reset values: all outputs 0; FIFO empty; state IDLE; pace counter 0.
- A reset mid-download discards all buffered data and returns to IDLE.
- download_fall below means ioctl_download sampled 1 last cycle and 0 this cycle.
- State IDLE:
  - ioctl_wr ignored.
  - On ioctl_download = 1: clear FIFO pointers, byte_count and overflow; latch out_index <= ioctl_index; go to LOAD.
- State LOAD:
  - ioctl_wr with FIFO not full: push ioctl_dout; byte_count += 1, saturating at 22'h3FFFFF.
  - ioctl_wr with FIFO full: byte dropped; overflow <= 1; byte_count unchanged.
  - On download_fall: go to DRAIN.
  - A write arriving in the same cycle as the fall is still accepted.
- State DRAIN:
  - No pushes.
  - When the FIFO is empty and no strobe is pending: load hold counter with RST_HOLD and go to HOLD.
- State HOLD:
  - Decrement the hold counter each cycle; at 0, go to IDLE.
  - ioctl_download = 1 in HOLD: restart as in IDLE and go to LOAD.
- download_reset: combinational from state; 1 in LOAD, DRAIN and HOLD, 0 in IDLE. Total high time after the last strobe is RST_HOLD+1 cycles.
- Output side (LOAD and DRAIN only):
  - out_strobe is registered. It asserts the cycle after a cycle in which FIFO non-empty, out_ready = 1 and pace counter = 0.
  - That cycle pops the head into out_data and reloads pace counter = PACE-1.
  - The pace counter decrements to 0 otherwise.
  - Minimum latency from push to out_strobe: 2 cycles when the FIFO is empty.
  - out_data holds its value between strobes.
- Simultaneous push and pop: both occur; occupancy unchanged; full/empty evaluated on pre-cycle occupancy.
- Occupancy: AW+1-bit count, range 0..DEPTH.
- ioctl_wait: registered; 1 when occupancy >= DEPTH-2 at cycle end, else 0; forced 0 in IDLE. This gives two entries of slack for an in-flight HPS write.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: IOCTL_STREAM_CHECKSUM_EN.
- Defined:
  - Adds output checksum [15:0], cleared on LOAD entry.
  - Adds checksum += out_data (mod 2^16) for each out_strobe.
  - Adds output checksum_valid (1 bit), asserted on HOLD entry and cleared on LOAD entry.
- Undefined: both ports absent, no associated logic.

Test Plan:
- Basic flow: index=0x01, download 4 bytes 0x4E,0x45,0x53,0x1A with 1 write per 10 cycles, out_ready=1 -> four strobes in order, first 2 cycles after its push; byte_count=4; download_reset high until 256 cycles after the last strobe.
- Pacing: 8 back-to-back writes, PACE=4 -> strobes exactly 4 cycles apart; ioctl_wait never asserts.
- Back-pressure: out_ready=0, 14 writes -> ioctl_wait=1 after the 14th push; release out_ready -> ioctl_wait falls once occupancy < 14; no byte lost.
- Overflow: out_ready=0, ignore wait, 17 writes -> overflow=1, byte_count=16, 16 bytes later emitted; overflow clears at next download start.
- Re-download in HOLD: raise ioctl_download 100 cycles into HOLD with index=0x00 -> returns to LOAD, out_index=0x00, byte_count=0, download_reset stays 1 continuously.
- Reset mid-LOAD with 5 bytes buffered -> next cycle all outputs 0, no further strobes; checksum (if enabled) 0.
